mem_access: RTL and testbench

Data-memory access stage between the ALU and the register-file write-back in the Decoder. Takes the effective address (ALU result), store data (rs2) and funct3. Runs a small FSM against a synchronous block RAM or a handshaked MMIO bus. Returns right-aligned load data to the write-back mux and stalls the core until the access completes.

---
 rtl/mem_access_pkg.sv | 55 +++++
 rtl/mem_lane_align.sv | 43 ++++
 rtl/mem_access.sv | 173 +++++++++++++++++
 tb/tb_mem_access.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access stage: funct3 load/store codes,
// MMIO base, access-size decode and alignment helpers.
package mem_access_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_FC00;
  localparam logic [31:0] TIMEOUT_FILL      = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Codes outside the valid set for the access direction fall back to a word access.
  function automatic acc_size_e decode_size(input logic [2:0] f3, input logic is_store);
    acc_size_e sz;
    sz = SZ_WORD;
    if (is_store) begin
      case (f3)
        F3_SB:   sz = SZ_BYTE;
        F3_SH:   sz = SZ_HALF;
        F3_SW:   sz = SZ_WORD;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: sz = SZ_BYTE;
        F3_LH, F3_LHU: sz = SZ_HALF;
        F3_LW:         sz = SZ_WORD;
        default:       sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  function automatic logic misaligned(input acc_size_e sz, input logic [1:0] off);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic shared by the RAM and IO paths: store byte enables,
// lane-replicated and right-aligned store data, and load shift/mask.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  acc_size_e   size,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  byte_we,
  output logic [31:0] wdata_lane,
  output logic [31:0] wdata_right,
  output logic [31:0] load_aligned
);

  logic [31:0] shifted;

  always_comb begin
    shifted      = load_raw >> {offset, 3'b000};
    byte_we      = 4'b1111;
    wdata_lane   = store_data;
    wdata_right  = store_data;
    load_aligned = shifted;
    case (size)
      SZ_BYTE: begin
        byte_we      = 4'b0001 << offset;
        wdata_lane   = {4{store_data[7:0]}};
        wdata_right  = {24'h0, store_data[7:0]};
        load_aligned = {24'h0, shifted[7:0]};
      end
      SZ_HALF: begin
        byte_we      = 4'b0011 << {offset[1], 1'b0};
        wdata_lane   = {2{store_data[15:0]}};
        wdata_right  = {16'h0, store_data[15:0]};
        load_aligned = {16'h0, shifted[15:0]};
      end
      default: begin
        byte_we      = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Data-memory access stage: routes loads/stores to block RAM or the MMIO bus and
// stalls the core until done. Optional IO timeout: define MEM_ACCESS_TIMEOUT_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int          RAM_AW         = 14,
  parameter logic [31:0] MMIO_BASE      = MMIO_BASE_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              misalign,
  output logic              io_timeout,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RAM_RD  = 2'd1;
  localparam logic [1:0] S_IO_WAIT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]  state;
  logic        req;
  logic        is_store;
  logic        is_io;
  logic        bad_align;
  acc_size_e   req_size;
  acc_size_e   acc_size;
  acc_size_e   align_size;
  logic [1:0]  acc_off;
  logic [1:0]  align_off;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] right_wdata;
  logic [31:0] load_raw;
  logic [31:0] load_aligned;

  // A simultaneous read and write performs only the read.
  assign req       = mem_read | mem_write;
  assign is_store  = mem_write & ~mem_read;
  assign is_io     = (addr >= MMIO_BASE);
  assign req_size  = decode_size(funct3, is_store);
  assign bad_align = misaligned(req_size, addr[1:0]);

  // In IDLE the lanes follow the live request; afterwards the latched access drives them.
  always_comb begin
    align_size = acc_size;
    align_off  = acc_off;
    if (state == S_IDLE) begin
      align_size = req_size;
      align_off  = addr[1:0];
    end
  end

  assign load_raw = (state == S_IO_WAIT) ? io_rdata : ram_rdata;

  mem_lane_align u_align (
    .size         (align_size),
    .offset       (align_off),
    .store_data   (store_data),
    .load_raw     (load_raw),
    .byte_we      (lane_we),
    .wdata_lane   (lane_wdata),
    .wdata_right  (right_wdata),
    .load_aligned (load_aligned)
  );

  assign stall     = req && (state != S_DONE);
  assign ram_en    = ~rst && (state == S_IDLE) && req && ~bad_align && ~is_io;
  assign ram_we    = (ram_en && is_store) ? lane_we : 4'b0000;
  assign ram_addr  = addr[RAM_AW+1:2];
  assign ram_wdata = lane_wdata;
  assign fsm_state = state;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] tmo_cnt;
`else
  // Expression is never true; the IO wait is unbounded in this build.
  assign io_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      load_data <= '0;
      io_req    <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= '0;
      io_wdata  <= '0;
      misalign  <= 1'b0;
      acc_size  <= SZ_WORD;
      acc_off   <= 2'b00;
`ifdef MEM_ACCESS_TIMEOUT_EN
      io_timeout <= 1'b0;
      tmo_cnt    <= '0;
`endif
    end else begin
      misalign <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      io_timeout <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (req) begin
            acc_size <= req_size;
            acc_off  <= addr[1:0];
            if (bad_align) begin
              misalign  <= 1'b1;
              load_data <= '0;
              state     <= S_DONE;
            end else if (is_io) begin
              io_req   <= 1'b1;
              io_we    <= is_store;
              io_addr  <= addr;
              io_wdata <= right_wdata;
`ifdef MEM_ACCESS_TIMEOUT_EN
              tmo_cnt  <= '0;
`endif
              state    <= S_IO_WAIT;
            end else if (mem_read) begin
              state <= S_RAM_RD;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_RAM_RD: begin
          load_data <= load_aligned;
          state     <= S_DONE;
        end
        S_IO_WAIT: begin
          if (io_ack) begin
            io_req <= 1'b0;
            if (!io_we) load_data <= load_aligned;
            state <= S_DONE;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            io_req     <= 1'b0;
            io_timeout <= 1'b1;
            load_data  <= TIMEOUT_FILL;
            state      <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: RAM loads/stores, lane enables, misalignment,
// MMIO handshake, reset mid-access and (with MEM_ACCESS_TIMEOUT_EN) IO timeout.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic [31:0] load_data;
  logic        misalign;
  logic        io_timeout;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        io_req;
  logic        io_we;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ack;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ram_mem [0:63];

  // observations captured by the access task
  logic        seen_ram_en;
  logic [3:0]  seen_ram_we;
  logic [31:0] seen_ram_wdata;
  logic [13:0] seen_ram_addr;
  logic        seen_io_we;
  logic [31:0] seen_io_addr;
  logic [31:0] seen_io_wdata;
  logic [1:0]  done_state;
  logic        done_misalign;
  logic        done_timeout;
  int          last_stall;
  int          last_req;

  mem_access #(
    .RAM_AW         (14),
    .MMIO_BASE      (32'hFFFF_FC00),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .load_data  (load_data),
    .misalign   (misalign),
    .io_timeout (io_timeout),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .io_req     (io_req),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .io_ack     (io_ack),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // synchronous block RAM model, read data one cycle after ram_en
  always @(posedge clk) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) ram_mem[ram_addr[5:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
      ram_rdata <= ram_mem[ram_addr[5:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = d;
  endtask

  // Starts in an IDLE cycle (negedge+1), holds the request while stalled, answers
  // io_req with io_ack on its ack_after-th cycle (0 = never), ends one cycle after DONE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                        input int ack_after, input logic [31:0] rdata);
    drive(rd, wr, f3, a, d);
    #1;
    seen_ram_en    = ram_en;
    seen_ram_we    = ram_we;
    seen_ram_wdata = ram_wdata;
    seen_ram_addr  = ram_addr;
    last_stall = 0;
    last_req   = 0;
    while (stall && last_stall < 300) begin
      last_stall++;
      if (io_req) begin
        last_req++;
        if (last_req == 1) begin
          seen_io_we    = io_we;
          seen_io_addr  = io_addr;
          seen_io_wdata = io_wdata;
        end
        if (last_req == ack_after) begin
          io_ack   = 1'b1;
          io_rdata = rdata;
        end
      end
      @(negedge clk);
      #1;
      io_ack = 1'b0;
    end
    done_state    = fsm_state;
    done_misalign = misalign;
    done_timeout  = io_timeout;
    if (rd) begin
      if (exp_q.size() == 0) chk({tag, "_queue"}, 32'h0, 32'h1);
      else chk({tag, "_data"}, load_data, exp_q.pop_front());
    end
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram_mem[i] = 32'h0;
    rst = 1'b1;
    io_ack = 1'b0;
    io_rdata = 32'h0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    #1;

    chk("rst_state", {30'h0, fsm_state}, {30'h0, ST_IDLE});
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_io_req", {31'h0, io_req}, 32'h0);
    chk("rst_io_we", {31'h0, io_we}, 32'h0);
    chk("rst_io_addr", io_addr, 32'h0);
    chk("rst_io_wdata", io_wdata, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_io_timeout", {31'h0, io_timeout}, 32'h0);
    chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
    chk("rst_ram_we", {28'h0, ram_we}, 32'h0);

    // store with reset still asserted must not write
    drive(1'b0, 1'b1, F3_SW, 32'h20, 32'hFFFF_FFFF);
    #1;
    chk("rst_store_we", {28'h0, ram_we}, 32'h0);
    chk("rst_store_en", {31'h0, ram_en}, 32'h0);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    // SW then LW
    access("sw", 1'b0, 1'b1, F3_SW, 32'h10, 32'h1234_5678, 0, 32'h0);
    chk("sw_stall", last_stall, 1);
    chk("sw_we", {28'h0, seen_ram_we}, 32'hF);
    chk("sw_addr", {18'h0, seen_ram_addr}, 32'h4);
    chk("sw_wdata", seen_ram_wdata, 32'h1234_5678);
    chk("sw_done_state", {30'h0, done_state}, {30'h0, ST_DONE});
    chk("after_done_idle", {30'h0, fsm_state}, {30'h0, ST_IDLE});
    exp_q.push_back(32'h1234_5678);
    access("lw", 1'b1, 1'b0, F3_LW, 32'h10, 32'h0, 0, 32'h0);
    chk("lw_stall", last_stall, 2);
    chk("lw_en", {31'h0, seen_ram_en}, 32'h1);

    // SB then byte/half loads
    access("sb", 1'b0, 1'b1, F3_SB, 32'h13, 32'h0000_00AB, 0, 32'h0);
    chk("sb_we", {28'h0, seen_ram_we}, 32'h8);
    chk("sb_wdata", seen_ram_wdata, 32'hABAB_ABAB);
    chk("sb_stall", last_stall, 1);
    exp_q.push_back(32'h0000_00AB);
    access("lbu", 1'b1, 1'b0, F3_LBU, 32'h13, 32'h0, 0, 32'h0);
    exp_q.push_back(32'h0000_AB34);
    access("lhu", 1'b1, 1'b0, F3_LHU, 32'h12, 32'h0, 0, 32'h0);
    exp_q.push_back(32'h0000_0056);
    access("lb", 1'b1, 1'b0, F3_LB, 32'h11, 32'h0, 0, 32'h0);

    // SH upper half, read back as a word
    access("sh", 1'b0, 1'b1, F3_SH, 32'h16, 32'h1111_BEEF, 0, 32'h0);
    chk("sh_we", {28'h0, seen_ram_we}, 32'hC);
    chk("sh_wdata", seen_ram_wdata, 32'hBEEF_BEEF);
    exp_q.push_back(32'hBEEF_0000);
    access("lw14", 1'b1, 1'b0, F3_LW, 32'h14, 32'h0, 0, 32'h0);

    // misaligned half load: load_data was nonzero before
    exp_q.push_back(32'h0);
    access("lh_mis", 1'b1, 1'b0, F3_LH, 32'h11, 32'h0, 0, 32'h0);
    chk("lh_mis_stall", last_stall, 1);
    chk("lh_mis_en", {31'h0, seen_ram_en}, 32'h0);
    chk("lh_mis_pulse", {31'h0, done_misalign}, 32'h1);
    chk("lh_mis_pulse_end", {31'h0, misalign}, 32'h0);
    access("sw_mis", 1'b0, 1'b1, F3_SW, 32'h12, 32'h0, 0, 32'h0);
    chk("sw_mis_we", {28'h0, seen_ram_we}, 32'h0);
    chk("sw_mis_pulse", {31'h0, done_misalign}, 32'h1);

    // read and write together: only the read happens
    exp_q.push_back(32'hAB34_5678);
    access("rw_both", 1'b1, 1'b1, F3_LW, 32'h10, 32'hFFFF_FFFF, 0, 32'h0);
    chk("rw_both_we", {28'h0, seen_ram_we}, 32'h0);
    chk("rw_both_stall", last_stall, 2);

    // unknown funct3 is a word access
    exp_q.push_back(32'hBEEF_0000);
    access("unk_ld", 1'b1, 1'b0, 3'b011, 32'h14, 32'h0, 0, 32'h0);
    access("unk_st", 1'b0, 1'b1, F3_LBU, 32'h18, 32'hCAFE_F00D, 0, 32'h0);
    chk("unk_st_we", {28'h0, seen_ram_we}, 32'hF);
    exp_q.push_back(32'hCAFE_F00D);
    access("unk_rb", 1'b1, 1'b0, F3_LW, 32'h18, 32'h0, 0, 32'h0);

    // IO word load, ack on the 5th request cycle
    exp_q.push_back(32'h0000_0055);
    access("io_lw", 1'b1, 1'b0, F3_LW, 32'hFFFF_FC00, 32'h0, 5, 32'h0000_0055);
    chk("io_lw_req_cycles", last_req, 5);
    chk("io_lw_stall", last_stall, 6);
    chk("io_lw_addr", seen_io_addr, 32'hFFFF_FC00);
    chk("io_lw_we", {31'h0, seen_io_we}, 32'h0);
    chk("io_lw_ram_en", {31'h0, seen_ram_en}, 32'h0);
    chk("io_lw_req_drop", {31'h0, io_req}, 32'h0);

    // IO byte store (right-aligned data) and IO byte load (shifted)
    access("io_sb", 1'b0, 1'b1, F3_SB, 32'hFFFF_FC03, 32'h1234_56AB, 1, 32'h0);
    chk("io_sb_wdata", seen_io_wdata, 32'h0000_00AB);
    chk("io_sb_we", {31'h0, seen_io_we}, 32'h1);
    chk("io_sb_stall", last_stall, 2);
    exp_q.push_back(32'h0000_00CC);
    access("io_lbu", 1'b1, 1'b0, F3_LBU, 32'hFFFF_FC02, 32'h0, 2, 32'h00CC_0000);

`ifdef MEM_ACCESS_TIMEOUT_EN
    exp_q.push_back(32'hDEAD_BEEF);
    access("io_tmo", 1'b1, 1'b0, F3_LW, 32'hFFFF_FC04, 32'h0, 0, 32'h0);
    chk("io_tmo_req_cycles", last_req, 8);
    chk("io_tmo_stall", last_stall, 9);
    chk("io_tmo_pulse", {31'h0, done_timeout}, 32'h1);
    chk("io_tmo_pulse_end", {31'h0, io_timeout}, 32'h0);
`endif

    // reset while waiting on the IO bus
    drive(1'b1, 1'b0, F3_LW, 32'hFFFF_FC08, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_io_pre_req", {31'h0, io_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_io_req", {31'h0, io_req}, 32'h0);
    chk("rst_io_state", {30'h0, fsm_state}, {30'h0, ST_IDLE});
    chk("rst_io_stall_req", {31'h0, stall}, 32'h1);
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    chk("rst_io_stall_idle", {31'h0, stall}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
